// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter that grants CLIENT_CNT requesters, one at a time,
// onto a single downstream memory port, with a sticky watchdog on long grants.
module mem_arb #(
  parameter int M_WIDTH    = 8,
  parameter int CLIENT_CNT = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CLIENT_CNT-1:0]            requests,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]    client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]            client_wes,
  input  logic [2*CLIENT_CNT-1:0]          client_data_widths_packed,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]    client_data_outs_packed,
  output logic [CLIENT_CNT*M_WIDTH-1:0]    client_data_ins_packed,
  output logic [CLIENT_CNT-1:0]            client_readies,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [M_WIDTH-1:0]               mem_addr,
  output logic [M_WIDTH-1:0]               mem_data_out,
  output logic [1:0]                       mem_width,
  input  logic [M_WIDTH-1:0]               mem_data_in,
  input  logic                             mem_ready,
  output logic [$clog2(CLIENT_CNT)-1:0]    owner,
  output logic                             timeout_err
);

  localparam int IW = $clog2(CLIENT_CNT);
  localparam logic [4:0] TIMEOUT_CMP = 5'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       owner_reg, last_reg, pick, cand;
  logic                found;
  logic [M_WIDTH-1:0]  addr_reg, data_reg;
  logic                we_reg;
  logic [1:0]          width_reg;
  logic [3:0]          cnt_reg;
  logic                err_reg;
  logic                start, complete;

  assign start    = (state_reg == IDLE) && (|requests);
  assign complete = (state_reg == GRANT) && mem_ready;

  // Scan upward from last+1; index arithmetic wraps because CLIENT_CNT is a power of two.
  always_comb begin
    pick  = last_reg;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= CLIENT_CNT; k++) begin
      cand = last_reg + IW'(k);
      if (!found && requests[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = GRANT;
      GRANT:   if (mem_ready) state_next = DONE;
      DONE:    if (!requests[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req        = 1'b0;
    client_readies = '0;
    case (state_reg)
      GRANT:   mem_req = 1'b1;
      DONE:    client_readies[owner_reg] = requests[owner_reg];
      default: ;
    endcase
  end

  assign mem_addr     = addr_reg;
  assign mem_data_out = data_reg;
  assign mem_we       = we_reg;
  assign mem_width    = width_reg;
  assign owner        = owner_reg;
  assign timeout_err  = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg <= '0;
      last_reg  <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      we_reg    <= 1'b0;
      width_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (start) begin
        owner_reg <= pick;
        addr_reg  <= client_addrs_packed[pick*M_WIDTH +: M_WIDTH];
        data_reg  <= client_data_outs_packed[pick*M_WIDTH +: M_WIDTH];
        we_reg    <= client_wes[pick];
        width_reg <= client_data_widths_packed[pick*2 +: 2];
        cnt_reg   <= '0;
      end
      // Saturated counter never reaches values above 15, so the flag cannot fire there.
      if (state_reg == GRANT && !mem_ready && cnt_reg != 4'hF) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (({1'b0, cnt_reg} + 5'd1) == TIMEOUT_CMP) err_reg <= 1'b1;
      end
      if (state_reg == DONE && !requests[owner_reg]) last_reg <= owner_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CLIENT_CNT; gi++) begin : g_slice
      logic [M_WIDTH-1:0] slice_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   slice_reg <= '0;
        else if (complete && owner_reg == IW'(gi))  slice_reg <= mem_data_in;
      end
      assign client_data_ins_packed[gi*M_WIDTH +: M_WIDTH] = slice_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic
// against a transaction-level round-robin model.
module tb_mem_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   requests = '0;
  logic [N*W-1:0] addrs = '0, douts = '0, dins;
  logic [N-1:0]   wes = '0, readies;
  logic [2*N-1:0] widths = '0;
  logic           mem_req, mem_we, mem_ready = 1'b0;
  logic [W-1:0]   mem_addr, mem_data_out, mem_data_in = '0;
  logic [1:0]     mem_width, owner;
  logic           timeout_err;

  int total = 0;
  int bad   = 0;
  int last_m = 0;
  logic [W-1:0] din_m [N];

  always #5 clk = ~clk;

  mem_arb #(.M_WIDTH(W), .CLIENT_CNT(N), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .requests(requests),
    .client_addrs_packed(addrs), .client_wes(wes),
    .client_data_widths_packed(widths), .client_data_outs_packed(douts),
    .client_data_ins_packed(dins), .client_readies(readies),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_width(mem_width),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .owner(owner), .timeout_err(timeout_err)
  );

  // Round-robin rule: first requester at or after last+1, wrapping.
  function automatic int rr_pick(int last, logic [N-1:0] req);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack_model();
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = din_m[i];
    return p;
  endfunction

  task automatic set_client(int i, logic [W-1:0] a, logic we, logic [1:0] w, logic [W-1:0] d);
    addrs[i*W +: W]  = a;
    wes[i]           = we;
    widths[2*i +: 2] = w;
    douts[i*W +: W]  = d;
  endtask

  task automatic rand_clients();
    for (int i = 0; i < N; i++)
      set_client(i, W'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), W'($urandom));
  endtask

  // Leaves the bench at a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; requests = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_m = 0;
    for (int i = 0; i < N; i++) din_m[i] = '0;
  endtask

  task automatic wait_grant(output bit ok, output int lows);
    ok = 1'b0; lows = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_req) begin ok = 1'b1; break; end
      lows++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; requests = '1; mem_ready = 1'b1;
    #1;
    total++; if ({mem_req, readies, owner, timeout_err} !== '0) begin bad++;
      $display("FAIL reset_ctrl got=%0h want=0", {mem_req, readies, owner, timeout_err}); end
    total++; if (dins !== '0) begin bad++; $display("FAIL reset_dins got=%0h want=0", dins); end
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_hold_req got=%0b want=0", mem_req); end
    requests = '0; mem_ready = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    bit ok; int lows;
    do_reset();
    set_client(2, 8'h10, 1'b0, 2'b00, 8'h77);
    requests = 4'b0100;
    wait_grant(ok, lows);
    total++; if (!ok || lows != 0) begin bad++; $display("FAIL sr_grant ok=%0b lows=%0d want ok=1 lows=0", ok, lows); end
    total++; if (owner !== 2'd2) begin bad++; $display("FAIL sr_owner got=%0d want=2", owner); end
    total++; if ({mem_addr, mem_we, mem_width} !== {8'h10, 1'b0, 2'b00}) begin bad++;
      $display("FAIL sr_port addr=%0h we=%0b w=%0d want 10/0/0", mem_addr, mem_we, mem_width); end
    repeat (2) @(negedge clk);
    mem_ready = 1'b1; mem_data_in = 8'hA5;
    @(negedge clk);
    mem_ready = 1'b0;
    din_m[2] = 8'hA5;
    total++; if (dins !== pack_model()) begin bad++; $display("FAIL sr_dins got=%0h want=%0h", dins, pack_model()); end
    for (int c = 0; c < 2; c++) begin
      total++; if (readies !== 4'b0100 || mem_req !== 1'b0) begin bad++;
        $display("FAIL sr_ready got=%b req=%0b want=0100 req=0", readies, mem_req); end
      if (c == 0) @(negedge clk);
    end
    requests = '0;
    #1;
    total++; if (readies !== 4'b0000) begin bad++; $display("FAIL sr_ready_drop got=%b want=0000", readies); end
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || readies !== '0) begin bad++;
      $display("FAIL sr_idle req=%0b rdy=%b want 0/0000", mem_req, readies); end
    last_m = 2;
  endtask

  task automatic test_round_robin();
    bit ok; int lows; int exp_order [5];
    exp_order = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) set_client(i, W'(8'h20 + i), 1'b0, 2'b01, W'(8'h50 + i));
    requests = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(ok, lows);
      total++; if (!ok || int'(owner) != exp_order[t] || int'(owner) != rr_pick(last_m, requests)) begin bad++;
        $display("FAIL rr_order step=%0d got=%0d want=%0d ok=%0b", t, owner, exp_order[t], ok); end
      total++; if (mem_addr !== W'(8'h20 + exp_order[t])) begin bad++;
        $display("FAIL rr_addr step=%0d got=%0h want=%0h", t, mem_addr, 8'h20 + exp_order[t]); end
      mem_ready = 1'b1; mem_data_in = W'(8'hC0 + t);
      @(negedge clk);
      mem_ready = 1'b0;
      total++; if (readies !== 4'(1 << exp_order[t]) || mem_req !== 1'b0) begin bad++;
        $display("FAIL rr_done step=%0d rdy=%b req=%0b", t, readies, mem_req); end
      requests[exp_order[t]] = 1'b0;
      @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rr_gap step=%0d req=%0b want=0", t, mem_req); end
      last_m = exp_order[t];
      requests[exp_order[t]] = 1'b1;
    end
  endtask

  task automatic test_latch_stability();
    bit ok; int lows;
    do_reset();
    set_client(0, 8'h40, 1'b1, 2'b00, 8'h3C);
    requests = 4'b0001;
    wait_grant(ok, lows);
    total++; if (!ok || owner !== 2'd0) begin bad++; $display("FAIL ls_grant ok=%0b owner=%0d want 1/0", ok, owner); end
    set_client(0, 8'hEE, 1'b0, 2'b10, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if ({mem_req, mem_data_out, mem_we, mem_addr, mem_width} !== {1'b1, 8'h3C, 1'b1, 8'h40, 2'b00}) begin bad++;
        $display("FAIL ls_stable cyc=%0d req=%0b dout=%0h we=%0b addr=%0h w=%0d", c, mem_req, mem_data_out, mem_we, mem_addr, mem_width); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; requests = '0;
    @(negedge clk);
  endtask

  task automatic test_withdrawal();
    bit ok; int lows; bit saw_ready;
    do_reset();
    set_client(3, 8'h33, 1'b0, 2'b10, 8'h00);
    requests = 4'b1000;
    wait_grant(ok, lows);
    total++; if (!ok || owner !== 2'd3) begin bad++; $display("FAIL wd_grant ok=%0b owner=%0d want 1/3", ok, owner); end
    requests = '0;
    saw_ready = 1'b0;
    @(negedge clk);
    saw_ready |= |readies;
    mem_ready = 1'b1; mem_data_in = 8'h99;
    @(negedge clk);
    mem_ready = 1'b0;
    saw_ready |= |readies;
    din_m[3] = 8'h99;
    total++; if (dins !== pack_model() || mem_req !== 1'b0) begin bad++;
      $display("FAIL wd_complete dins=%0h want=%0h req=%0b", dins, pack_model(), mem_req); end
    total++; if (saw_ready) begin bad++; $display("FAIL wd_no_ready got=1 want=0"); end
    @(negedge clk);
    requests = 4'b1111;
    wait_grant(ok, lows);
    total++; if (!ok || lows != 0 || owner !== 2'd0) begin bad++;
      $display("FAIL wd_next ok=%0b lows=%0d owner=%0d want 1/0/0", ok, lows, owner); end
  endtask

  task automatic test_watchdog();
    bit ok; int lows;
    do_reset();
    requests = 4'b0010;
    wait_grant(ok, lows);
    total++; if (!ok || timeout_err !== 1'b0) begin bad++; $display("FAIL wdog_start ok=%0b err=%0b want 1/0", ok, timeout_err); end
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || timeout_err !== (k >= 15)) begin bad++;
        $display("FAIL wdog_cycle k=%0d req=%0b err=%0b want 1/%0b", k, mem_req, timeout_err, k >= 15); end
    end
    #2 rst = 1'b0;
    #1;
    total++; if ({mem_req, timeout_err, readies, owner} !== '0 || dins !== '0) begin bad++;
      $display("FAIL wdog_async_rst req=%0b err=%0b rdy=%b owner=%0d", mem_req, timeout_err, readies, owner); end
    @(negedge clk);
    rst = 1'b1;
    last_m = 0;
    for (int i = 0; i < N; i++) din_m[i] = '0;
    wait_grant(ok, lows);
    total++; if (!ok || lows != 0 || owner !== 2'd1) begin bad++;
      $display("FAIL wdog_first_grant ok=%0b lows=%0d owner=%0d want 1/0/1", ok, lows, owner); end
  endtask

  task automatic test_back_to_back();
    bit ok; int lows; int gap;
    do_reset();
    set_client(1, 8'h11, 1'b1, 2'b01, 8'h22);
    requests = 4'b0010;
    wait_grant(ok, lows);
    for (int t = 0; t < 3; t++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; requests = '0;
      @(negedge clk);
      requests = 4'b0010;
      wait_grant(ok, lows);
      gap = lows + 2;
      total++; if (!ok || gap != 2 || owner !== 2'd1) begin bad++;
        $display("FAIL b2b_gap t=%0d ok=%0b gap=%0d owner=%0d want 1/2/1", t, ok, gap, owner); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; requests = '0;
  endtask

  task automatic test_random();
    bit ok; int lows; int exp, lat, dwell; bit withdraw;
    logic [W-1:0] e_addr, e_data, rdata; logic e_we; logic [1:0] e_w;
    do_reset();
    rand_clients();
    requests = N'($urandom);
    if (requests == '0) requests[0] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      exp    = rr_pick(last_m, requests);
      e_addr = addrs[exp*W +: W]; e_data = douts[exp*W +: W];
      e_we   = wes[exp];          e_w    = widths[2*exp +: 2];
      wait_grant(ok, lows);
      total++; if (!ok || lows != 0 || int'(owner) != exp) begin bad++;
        $display("FAIL rnd_grant t=%0d ok=%0b lows=%0d owner=%0d want=%0d", t, ok, lows, owner, exp); end
      lat = $urandom_range(0, 4);
      withdraw = (lat > 0) && ($urandom_range(0, 3) == 0);
      for (int j = 0; j < lat; j++) begin
        rand_clients();
        if (withdraw && j == 0) requests[exp] = 1'b0;
        @(negedge clk);
        total++; if ({mem_req, readies, mem_addr, mem_data_out, mem_we, mem_width} !== {1'b1, 4'b0, e_addr, e_data, e_we, e_w}) begin bad++;
          $display("FAIL rnd_hold t=%0d req=%0b rdy=%b addr=%0h/%0h dout=%0h/%0h we=%0b/%0b w=%0d/%0d", t, mem_req, readies, mem_addr, e_addr, mem_data_out, e_data, mem_we, e_we, mem_width, e_w); end
      end
      rdata = W'($urandom);
      mem_ready = 1'b1; mem_data_in = rdata;
      din_m[exp] = rdata;
      @(negedge clk);
      mem_ready = 1'($urandom); mem_data_in = W'($urandom);
      total++; if (mem_req !== 1'b0 || readies !== (withdraw ? 4'b0 : 4'(1 << exp)) || dins !== pack_model()) begin bad++;
        $display("FAIL rnd_done t=%0d req=%0b rdy=%b dins=%0h want dins=%0h", t, mem_req, readies, dins, pack_model()); end
      dwell = withdraw ? 0 : $urandom_range(0, 2);
      for (int d = 0; d < dwell; d++) begin
        @(negedge clk);
        mem_ready = 1'($urandom);
        total++; if (mem_req !== 1'b0 || readies !== 4'(1 << exp)) begin bad++;
          $display("FAIL rnd_dwell t=%0d req=%0b rdy=%b", t, mem_req, readies); end
      end
      requests = requests | N'($urandom);
      requests[exp] = 1'b0;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || readies !== '0) begin bad++;
        $display("FAIL rnd_idle t=%0d req=%0b rdy=%b", t, mem_req, readies); end
      mem_ready = 1'b0;
      last_m = exp;
      rand_clients();
      requests = requests | N'($urandom);
      if (requests == '0) requests[$urandom_range(0, N-1)] = 1'b1;
    end
    requests = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) din_m[i] = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_latch_stability();
    test_withdrawal();
    test_watchdog();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
